// File: rtl/sqrt_pkg.sv
// Shared constants and encodings for the arbitrated bit-serial square-root block.
package sqrt_pkg;

  localparam int W  = 21;
  localparam int RW = (W + 1) / 2;
  localparam int CW = $clog2(RW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

endpackage

// File: rtl/sqrt_iter_core.sv
// Digit-by-digit restoring square root, one root bit per clock, MSB first.
// Optional SQRT_REM_OUT_EN exposes the final remainder x - root^2.
module sqrt_iter_core
  import sqrt_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  x,
  output logic [RW-1:0] root,
`ifdef SQRT_REM_OUT_EN
  output logic [RW:0]   rem,
`endif
  output logic          done
);

  localparam int XW = 2 * RW;

  logic [XW-1:0] r_x;
  logic [RW-1:0] r_root;
  logic [RW:0]   r_rem;
  logic [CW-1:0] r_cnt;
  logic          r_done;

  logic [XW-1:0] w_src_x;
  logic [RW-1:0] w_src_root;
  logic [RW:0]   w_src_rem;
  logic [RW+2:0] w_acc;
  logic [RW+2:0] w_trial;
  logic          w_keep;
  logic [RW:0]   w_rem_next;
  logic          w_step;

  // One iteration: bring down the next bit pair and test trial = 4*root + 1.
  always_comb begin
    w_src_x    = r_x;
    w_src_root = r_root;
    w_src_rem  = r_rem;
    if (start) begin
      w_src_x    = {{(XW - W){1'b0}}, x};
      w_src_root = '0;
      w_src_rem  = '0;
    end else begin
      w_src_x    = r_x;
      w_src_root = r_root;
      w_src_rem  = r_rem;
    end
    w_acc      = {w_src_rem, w_src_x[XW-1 -: 2]};
    w_trial    = {1'b0, w_src_root, 2'b01};
    w_keep     = (w_acc >= w_trial);
    // The remainder never exceeds 2*root, so RW+1 bits always hold it.
    w_rem_next = (RW + 1)'(w_keep ? (w_acc - w_trial) : w_acc);
  end

  assign w_step = start | (r_cnt != '0);

  // Iteration state; the first step is taken on the start edge itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x    <= '0;
      r_root <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_step) begin
        r_x    <= {w_src_x[XW-3:0], 2'b00};
        r_root <= {w_src_root[RW-2:0], w_keep};
        r_rem  <= w_rem_next;
        r_cnt  <= start ? CW'(RW - 1) : (r_cnt - CW'(1));
      end
      r_done <= ~start & (r_cnt == CW'(1));
    end
  end

  assign root = r_root;
`ifdef SQRT_REM_OUT_EN
  assign rem  = r_rem;
`endif
  assign done = r_done;

endmodule

// File: rtl/sqrt_arbiter_seq.sv
// Round-robin arbiter for two requesters sharing one iterative sqrt engine.
// Define SQRT_REM_OUT_EN to add the res_rem output (x - y^2).
module sqrt_arbiter_seq
  import sqrt_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [W-1:0]  a_x,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [W-1:0]  b_x,
  output logic          b_ready,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_id,
  output logic [W-1:0]  res_y,
`ifdef SQRT_REM_OUT_EN
  output logic [RW:0]   res_rem,
`endif
  output logic          busy
);

  state_t        r_state;
  logic          r_prefer_b;
  logic          r_op_id;
  logic          r_res_valid;
  logic          r_res_id;
  logic [W-1:0]  r_res_y;
  logic          r_busy;
`ifdef SQRT_REM_OUT_EN
  logic [RW:0]   r_res_rem;
  logic [RW:0]   w_rem;
`endif

  logic          w_idle;
  logic          w_grant_b;
  logic          w_hs;
  logic [W-1:0]  w_x;
  logic [RW-1:0] w_root;
  logic          w_done;

  assign w_idle    = (r_state == IDLE);
  // B wins when it is alone, or when both ask and A was served last.
  assign w_grant_b = b_valid & (~a_valid | r_prefer_b);
  assign a_ready   = ~rst & w_idle & a_valid & ~w_grant_b;
  assign b_ready   = ~rst & w_idle & w_grant_b;
  assign w_hs      = (a_valid & a_ready) | (b_valid & b_ready);
  assign w_x       = w_grant_b ? b_x : a_x;

  sqrt_iter_core u_core (
    .clk   (clk),
    .rst   (rst),
    .start (w_hs),
    .x     (w_x),
    .root  (w_root),
`ifdef SQRT_REM_OUT_EN
    .rem   (w_rem),
`endif
    .done  (w_done)
  );

  // Control FSM, round-robin pointer and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_prefer_b  <= 1'b0;
      r_op_id     <= ID_A;
      r_res_valid <= 1'b0;
      r_res_id    <= ID_A;
      r_res_y     <= '0;
      r_busy      <= 1'b0;
`ifdef SQRT_REM_OUT_EN
      r_res_rem   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_state    <= CALC;
            r_busy     <= 1'b1;
            r_op_id    <= w_grant_b ? ID_B : ID_A;
            r_prefer_b <= ~w_grant_b;
          end
        end
        CALC: begin
          if (w_done) begin
            r_state     <= DONE;
            r_res_valid <= 1'b1;
            r_res_y     <= {{(W - RW){1'b0}}, w_root};
            r_res_id    <= r_op_id;
`ifdef SQRT_REM_OUT_EN
            r_res_rem   <= w_rem;
`endif
          end
        end
        DONE: begin
          if (res_ready) begin
            r_state     <= IDLE;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_y     = r_res_y;
  assign busy      = r_busy;
`ifdef SQRT_REM_OUT_EN
  assign res_rem   = r_res_rem;
`endif

endmodule

// File: tb/tb_sqrt_arbiter_seq.sv
// Scoreboard bench for sqrt_arbiter_seq: stimulus pushes expected results, a monitor pops and checks.
module tb_sqrt_arbiter_seq;
  import sqrt_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0;
  logic          b_valid = 1'b0;
  logic [W-1:0]  a_x = '0;
  logic [W-1:0]  b_x = '0;
  logic          res_ready = 1'b0;
  logic          a_ready, b_ready, res_valid, res_id, busy;
  logic [W-1:0]  res_y;
`ifdef SQRT_REM_OUT_EN
  logic [RW:0]   res_rem;
`endif

  sqrt_arbiter_seq dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_x       (a_x),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_x       (b_x),
    .b_ready   (b_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_y     (res_y),
`ifdef SQRT_REM_OUT_EN
    .res_rem   (res_rem),
`endif
    .busy      (busy)
  );

  typedef struct {
    bit          id;
    logic [63:0] x;
    logic [63:0] y;
    bit          has_exp;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rr_mode = 0;
  int   hold_cnt = 0;
  int   xfers = 0;
  bit   m_prefer_b = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Consumer: always ready, random, or holding off 5 cycles after each result appears
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0: res_ready = 1'b1;
      1: res_ready = 1'($urandom_range(0, 1));
      default: begin
        if (res_valid) hold_cnt++;
        else hold_cnt = 0;
        res_ready = (hold_cnt > 5);
      end
    endcase
  end

  // Monitor: latency, stability while held, and result contents in grant order
  logic          prev_v = 1'b0;
  logic [W-1:0]  hold_y;
  logic          hold_id;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (a_ready && b_ready) chk("two_readys", 1'b1, 1'b0);
      if (res_valid && !prev_v) begin
        if (sb.size() == 0) begin
          chk("unexpected_res_valid", res_valid, 1'b0);
        end else begin
          chk("latency", 64'(cyc - sb[0].acc), 64'(RW));
        end
        hold_y  = res_y;
        hold_id = res_id;
      end else if (res_valid) begin
        chk("hold_y", res_y, hold_y);
        chk("hold_id", res_id, hold_id);
      end
      if (res_valid) chk("busy_with_result", busy, 1'b1);
      if (res_valid && res_ready && sb.size() > 0) begin
        exp_t e;
        logic [63:0] yy;
        e  = sb.pop_front();
        yy = 64'(res_y);
        xfers++;
        chk("res_id", res_id, e.id);
        if (e.has_exp) chk("res_y", yy, e.y);
        chk("sqrt_bound", (yy * yy <= e.x) && (e.x < (yy + 1) * (yy + 1)), 1'b1);
`ifdef SQRT_REM_OUT_EN
        chk("res_rem", 64'(res_rem), e.x - yy * yy);
`endif
      end
      prev_v = res_valid;
    end
  end

  // Present operands; predict grant order and push expected results at each handshake
  task automatic issue(input bit va, input logic [W-1:0] xa, input logic [63:0] ya,
                       input bit vb, input logic [W-1:0] xb, input logic [63:0] yb,
                       input bit he);
    bit pa, pb, g;
    int n;
    exp_t e;
    pa = va; pb = vb; n = 0;
    a_valid = va; a_x = xa;
    b_valid = vb; b_x = xb;
    while ((pa || pb) && n < 400) begin
      @(negedge clk);
      n++;
      if (a_ready || b_ready) begin
        g = (pa && pb) ? m_prefer_b : pb;
        chk("grant", {a_ready, b_ready}, g ? 2'b01 : 2'b10);
        e.id = g;
        e.x = g ? 64'(xb) : 64'(xa);
        e.y = g ? yb : ya;
        e.has_exp = he;
        e.acc = cyc + 1;
        sb.push_back(e);
        m_prefer_b = !g;
        @(posedge clk);
        #1;
        if (g) begin pb = 1'b0; b_valid = 1'b0; end
        else begin pa = 1'b0; a_valid = 1'b0; end
      end
    end
    if (pa || pb) chk("handshake_timeout", 1'b1, 1'b0);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || res_valid || busy) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", (sb.size() == 0) && !res_valid, 1'b1);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_y", res_y, 64'd0);
    chk("rst_res_id", res_id, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Single A request
    issue(1'b1, 21'd100, 64'd10, 1'b0, 21'd0, 64'd0, 1'b1);
    drain();

    // Zero operand, then B alone
    issue(1'b1, 21'd0, 64'd0, 1'b0, 21'd0, 64'd0, 1'b1);
    drain();
    issue(1'b0, 21'd0, 64'd0, 1'b1, 21'd99, 64'd9, 1'b1);
    drain();

    // Simultaneous requests twice: A, B, A, B
    issue(1'b1, 21'd50, 64'd7, 1'b1, 21'd81, 64'd9, 1'b1);
    drain();
    issue(1'b1, 21'd15, 64'd3, 1'b1, 21'd16, 64'd4, 1'b1);
    drain();

    // Full-scale operand with the consumer stalling
    rr_mode = 2;
    x0 = xfers;
    issue(1'b1, 21'd2097151, 64'd1448, 1'b0, 21'd0, 64'd0, 1'b1);
    drain();
    chk("single_transfer", 64'(xfers - x0), 64'd1);
    rr_mode = 0;

    // Reset in the 5th CALC cycle aborts the operation
    issue(1'b1, 21'd1000, 64'd31, 1'b0, 21'd0, 64'd0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("abort_res_valid", res_valid, 1'b0);
    chk("abort_res_y", res_y, 64'd0);
    chk("abort_res_id", res_id, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_a_ready", a_ready, 1'b0);
    chk("abort_b_ready", b_ready, 1'b0);
    sb.delete();
    m_prefer_b = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("no_result_after_abort", res_valid, 1'b0);
    issue(1'b1, 21'd144, 64'd12, 1'b1, 21'd400, 64'd20, 1'b1);
    drain();

    // Random operands and requester mix with a random consumer
    rr_mode = 1;
    for (int i = 0; i < 16; i++) begin
      int sel;
      logic [W-1:0] ra, rb;
      sel = $urandom_range(0, 2);
      ra  = W'($urandom_range(0, 2097151));
      rb  = W'($urandom_range(0, 2097151));
      issue(sel != 1, ra, 64'd0, sel != 0, rb, 64'd0, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();
    rr_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
